// File: rtl/turn_pattern_gen.sv
// turn_pattern_gen: animated lamp patterns for the tail-light controller.
// A shared prescaler produces a registered step strobe; the left, right and
// hazard channels each run their own small sequence machine off that strobe.
// Every output comes straight from a register.
module turn_pattern_gen #(
   parameter int TICK_DIV = 10,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       L,
   input  logic       H,
   input  logic       R,
   output logic [2:0] left_out,
   output logic [2:0] right_out,
   output logic [5:0] haz_out,
   output logic       tick
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   typedef enum logic [2:0] {D_OFF, D_S1, D_S2, D_S3, D_S0} dir_state_t;
   typedef enum logic [1:0] {H_OFF, H_ON, H_DARK} haz_state_t;

   logic             any_req;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             tick_reg, tick_next;
   logic [1:0]       dir_req;

   assign any_req = L | H | R;
   assign dir_req = {R, L};

   // Prescaler next value: parked at 0 while idle so a fresh request gets a
   // full first step; the strobe is raised for the cycle after the last count.
   always_comb begin
      cnt_next  = '0;
      tick_next = 1'b0;
      if (any_req) begin
         tick_next = (cnt_reg == CNT_LAST);
         cnt_next  = tick_next ? '0 : cnt_reg + CNT_W'(1);
      end
   end

   // Prescaler and strobe registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg  <= '0;
         tick_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         tick_reg <= tick_next;
      end
   end

   assign tick = tick_reg;

   // Left (gi=0) and right (gi=1) channels share one machine; the right
   // pattern is the left pattern mirrored so the innermost lamp lights first.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dir
         localparam bit MIRROR = (gi == 1);
         dir_state_t state_reg, state_next;
         logic [2:0] pat_reg, pat_next;
         logic [2:0] base_pat;

         // State and pattern registers for this direction channel.
         always_ff @(posedge clk) begin
            if (!rst) begin
               state_reg <= D_OFF;
               pat_reg   <= 3'b000;
            end else begin
               state_reg <= state_next;
               pat_reg   <= pat_next;
            end
         end

         // Next state: a dropped request wins over the step strobe.
         always_comb begin
            state_next = state_reg;
            if (!dir_req[gi]) begin
               state_next = D_OFF;
            end else begin
               case (state_reg)
                  D_OFF:   state_next = D_S1;
                  D_S1:    if (tick_reg) state_next = D_S2;
                  D_S2:    if (tick_reg) state_next = D_S3;
                  D_S3:    if (tick_reg) state_next = D_S0;
                  D_S0:    if (tick_reg) state_next = D_S1;
                  default: state_next = D_OFF;
               endcase
            end
         end

         // Pattern decoded from the next state so it lands with the state.
         always_comb begin
            base_pat = 3'b000;
            case (state_next)
               D_S1:    base_pat = 3'b001;
               D_S2:    base_pat = 3'b011;
               D_S3:    base_pat = 3'b111;
               default: base_pat = 3'b000;
            endcase
            pat_next = MIRROR ? {base_pat[0], base_pat[1], base_pat[2]} : base_pat;
         end
      end
   endgenerate

   assign left_out  = g_dir[0].pat_reg;
   assign right_out = g_dir[1].pat_reg;

   haz_state_t haz_state_reg, haz_state_next;
   logic [5:0] haz_pat_reg, haz_pat_next;

   // Hazard state and pattern registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         haz_state_reg <= H_OFF;
         haz_pat_reg   <= 6'b000000;
      end else begin
         haz_state_reg <= haz_state_next;
         haz_pat_reg   <= haz_pat_next;
      end
   end

   // Hazard next state: blink between ON and DARK on each step strobe.
   always_comb begin
      haz_state_next = haz_state_reg;
      if (!H) begin
         haz_state_next = H_OFF;
      end else begin
         case (haz_state_reg)
            H_OFF:   haz_state_next = H_ON;
            H_ON:    if (tick_reg) haz_state_next = H_DARK;
            H_DARK:  if (tick_reg) haz_state_next = H_ON;
            default: haz_state_next = H_OFF;
         endcase
      end
   end

   // Hazard pattern: all six lamps lit only in ON.
   always_comb begin
      haz_pat_next = (haz_state_next == H_ON) ? 6'b111111 : 6'b000000;
   end

   assign haz_out = haz_pat_reg;

endmodule

// File: tb/tb_turn_pattern_gen.sv
// Testbench for turn_pattern_gen: directed steps from the test plan followed
// by random request/reset traffic, each cycle compared against a step-count
// reference model.
module tb_turn_pattern_gen;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       L = 1'b0, H = 1'b0, R = 1'b0;
   logic [2:0] left_out, right_out;
   logic [5:0] haz_out;
   logic       tick;

   int total = 0;
   int bad   = 0;

   // Reference model: prescaler phase, strobe, and per-channel step counts.
   int  m_p    = 0;
   bit  m_tick = 1'b0;
   bit  m_act [3];
   int  m_n   [3];
   logic [2:0] lt [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
   logic [2:0] rt [4] = '{3'b100, 3'b110, 3'b111, 3'b000};

   turn_pattern_gen #(.TICK_DIV(TD), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .L         (L),
      .H         (H),
      .R         (R),
      .left_out  (left_out),
      .right_out (right_out),
      .haz_out   (haz_out),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] exp_left();
      return m_act[0] ? lt[m_n[0] % 4] : 3'b000;
   endfunction

   function automatic logic [2:0] exp_right();
      return m_act[1] ? rt[m_n[1] % 4] : 3'b000;
   endfunction

   function automatic logic [5:0] exp_haz();
      return (m_act[2] && (m_n[2] % 2 == 0)) ? 6'b111111 : 6'b000000;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, advance DUT and model, compare outputs.
   task automatic step(input logic r_v, input logic l_v, input logic h_v, input logic rr_v);
      bit req [3];
      bit prev_tick;
      bit any;
      rst = r_v; L = l_v; H = h_v; R = rr_v;
      @(posedge clk);
      req[0] = l_v; req[1] = rr_v; req[2] = h_v;
      if (!r_v) begin
         m_p = 0; m_tick = 1'b0;
         for (int c = 0; c < 3; c++) begin m_act[c] = 1'b0; m_n[c] = 0; end
      end else begin
         any       = l_v | h_v | rr_v;
         prev_tick = m_tick;
         m_tick    = any && (m_p == TD - 1);
         m_p       = any ? (m_p + 1) % TD : 0;
         for (int c = 0; c < 3; c++) begin
            if (!req[c])       m_act[c] = 1'b0;
            else if (!m_act[c]) begin m_act[c] = 1'b1; m_n[c] = 0; end
            else if (prev_tick) m_n[c]++;
         end
      end
      #1;
      chk("left",  {5'b0, left_out},  {5'b0, exp_left()});
      chk("right", {5'b0, right_out}, {5'b0, exp_right()});
      chk("haz",   {2'b0, haz_out},   {2'b0, exp_haz()});
      chk("tick",  {7'b0, tick},      {7'b0, m_tick});
   endtask

   initial begin
      int guard;
      bit rl, rh, rr;
      for (int c = 0; c < 3; c++) begin m_act[c] = 1'b0; m_n[c] = 0; end

      // Reset, then idle: nothing moves, tick stays low.
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

      // Left alone, then right joins on the shared phase.
      for (int i = 0; i < 18; i++) step(1, 1, 0, 0);
      for (int i = 0; i < 14; i++) step(1, 1, 0, 1);
      for (int i = 0; i < 2; i++)  step(1, 0, 0, 0);

      // Hazard alone; drop it on a strobe edge.
      for (int i = 0; i < 9; i++) step(1, 0, 1, 0);
      guard = 0;
      while (!m_tick && guard < 20) begin step(1, 0, 1, 0); guard++; end
      chk("haz_tick_found", {7'b0, m_tick}, 8'd1);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);

      // Drop L while showing 011, then re-raise: restarts at 001.
      guard = 0;
      step(1, 1, 0, 0);
      while (exp_left() != 3'b011 && guard < 20) begin step(1, 1, 0, 0); guard++; end
      chk("left_011_found", {5'b0, left_out}, 8'h03);
      step(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

      // Reset mid-sequence with everything active, release with requests held.
      for (int i = 0; i < 7; i++) step(1, 1, 1, 1);
      step(0, 1, 1, 1);
      for (int i = 0; i < 13; i++) step(1, 1, 1, 1);

      // Single-cycle requests.
      step(1, 0, 0, 0);
      step(1, 1, 1, 1);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);

      // Random traffic: requests toggle occasionally, rare resets.
      rl = 0; rh = 0; rr = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(7) == 0) rl = ~rl;
         if ($urandom_range(9) == 0) rh = ~rh;
         if ($urandom_range(7) == 0) rr = ~rr;
         step(($urandom_range(59) != 0), rl, rh, rr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
